// File: rtl/debug_entry_ctrl.sv
// Debug-mode entry sequencer: a debug request or eligible ebreak opens a constant-time
// multi-word password challenge; only a full match grants debug_mode_o. Optional lockout: DBG_UNLOCK_LOCKOUT_EN.
module debug_entry_ctrl #(
   parameter int PWD_WORDS   = 4,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 1024,
   parameter int TIMEOUT     = 256
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [1:0]                       priv_lvl_i,
   input  logic                             dcsr_ebreakm_i,
   input  logic                             dcsr_ebreaks_i,
   input  logic                             dcsr_ebreaku_i,
   input  logic                             ebreak_i,
   input  logic                             debug_req_i,
   input  logic                             resume_i,
   input  logic [32*PWD_WORDS-1:0]          pwd_ref_i,
   input  logic                             pwd_valid_i,
   input  logic [31:0]                      pwd_data_i,
   output logic                             pwd_ready_o,
   output logic                             challenge_o,
   output logic                             debug_mode_o,
   output logic                             unlock_fail_o,
   output logic                             locked_o,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt_o
);

   localparam int FW = $clog2(MAX_FAILS+1);
   localparam int IW = (PWD_WORDS > 1) ? $clog2(PWD_WORDS) : 1;
   localparam int TW = $clog2(TIMEOUT+1);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
   localparam logic [IW-1:0] IDX_LAST = IW'(PWD_WORDS-1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);
`ifdef DBG_UNLOCK_LOCKOUT_EN
   localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES-1);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CHAL, S_CHECK, S_DEBUG
`ifdef DBG_UNLOCK_LOCKOUT_EN
      , S_LOCKED
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          mismatch_q, mismatch_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [FW-1:0] fail_q, fail_d;
   logic          challenge_q, challenge_d;
   logic          ready_q, ready_d;
   logic          debug_q, debug_d;
   logic          fail_pulse_q, fail_pulse_d;
`ifdef DBG_UNLOCK_LOCKOUT_EN
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          locked_q, locked_d;
`endif

   logic          eligible;
   logic          trigger;
   logic          beat;
   logic [31:0]   cur_word;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mismatch_d   = mismatch_q;
      tmo_d        = tmo_q;
      fail_d       = fail_q;
      fail_pulse_d = 1'b0;
`ifdef DBG_UNLOCK_LOCKOUT_EN
      lock_cnt_d   = lock_cnt_q;
`endif

      case (priv_lvl_i)
         2'b11:   eligible = dcsr_ebreakm_i;
         2'b01:   eligible = dcsr_ebreaks_i;
         2'b00:   eligible = dcsr_ebreaku_i;
         default: eligible = 1'b0;
      endcase
      trigger  = debug_req_i || (ebreak_i && eligible);
      beat     = pwd_valid_i && ready_q;
      cur_word = pwd_ref_i[32*int'(idx_q) +: 32];

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d    = S_CHAL;
               idx_d      = '0;
               mismatch_d = 1'b0;
               tmo_d      = '0;
            end
         end
         S_CHAL: begin
            // No early exit on a bad word: every attempt consumes all beats.
            if (beat) begin
               mismatch_d = mismatch_q | (pwd_data_i != cur_word);
               tmo_d      = '0;
               if (idx_q == IDX_LAST) state_d = S_CHECK;
               else                   idx_d   = idx_q + IW'(1);
            end else if (tmo_q == TMO_LAST) begin
               mismatch_d = 1'b1;
               state_d    = S_CHECK;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_CHECK: begin
            if (!mismatch_q) begin
               state_d = S_DEBUG;
               fail_d  = '0;
            end else begin
               fail_pulse_d = 1'b1;
               fail_d       = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);
               state_d      = S_IDLE;
`ifdef DBG_UNLOCK_LOCKOUT_EN
               if (fail_d == FAIL_MAX) begin
                  state_d    = S_LOCKED;
                  lock_cnt_d = LOCK_INIT;
               end
`endif
            end
         end
         S_DEBUG: begin
            if (resume_i) state_d = S_IDLE;
         end
`ifdef DBG_UNLOCK_LOCKOUT_EN
         S_LOCKED: begin
            if (lock_cnt_q == '0) begin
               state_d = S_IDLE;
               fail_d  = '0;
            end else begin
               lock_cnt_d = lock_cnt_q - LW'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered off the next state so they line up with it.
      challenge_d = (state_d == S_CHAL);
      ready_d     = (state_d == S_CHAL);
      debug_d     = (state_d == S_DEBUG);
`ifdef DBG_UNLOCK_LOCKOUT_EN
      locked_d    = (state_d == S_LOCKED);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         mismatch_q   <= 1'b0;
         tmo_q        <= '0;
         fail_q       <= '0;
         challenge_q  <= 1'b0;
         ready_q      <= 1'b0;
         debug_q      <= 1'b0;
         fail_pulse_q <= 1'b0;
`ifdef DBG_UNLOCK_LOCKOUT_EN
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mismatch_q   <= mismatch_d;
         tmo_q        <= tmo_d;
         fail_q       <= fail_d;
         challenge_q  <= challenge_d;
         ready_q      <= ready_d;
         debug_q      <= debug_d;
         fail_pulse_q <= fail_pulse_d;
`ifdef DBG_UNLOCK_LOCKOUT_EN
         lock_cnt_q   <= lock_cnt_d;
         locked_q     <= locked_d;
`endif
      end
   end

   assign pwd_ready_o   = ready_q;
   assign challenge_o   = challenge_q;
   assign debug_mode_o  = debug_q;
   assign unlock_fail_o = fail_pulse_q;
   assign fail_cnt_o    = fail_q;
`ifdef DBG_UNLOCK_LOCKOUT_EN
   assign locked_o      = locked_q;
`else
   assign locked_o      = 1'b0;
`endif

endmodule

// File: doc/debug_entry_ctrl.md
# debug_entry_ctrl

Sequences entry into debug mode for the core's CSR file. A debug request or eligible `ebreak` starts a password challenge. `debug_mode_o`, which the CSR file uses to elevate privilege to M, is asserted only after a correct multi-word password. Repeated failures, including challenge timeouts, lock the controller out for a fixed period. The block sits beside the CSR regfile, between the debug module request and the regfile's `debug_mode` input.

## Interface
Parameters:
- `PWD_WORDS`, 4: password length in 32-bit words.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `LOCK_CYCLES`, 1024: lockout duration in cycles.
- `TIMEOUT`, 256: idle cycles allowed between challenge beats.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `priv_lvl_i`  in  2  current privilege (M=11, S=01, U=00, 10 reserved)
- `dcsr_ebreakm_i` / `dcsr_ebreaks_i` / `dcsr_ebreaku_i`  in  1 each  dcsr ebreak enables
- `ebreak_i`  in  1  one-cycle pulse, ebreak retired
- `debug_req_i`  in  1  level, external halt request
- `resume_i`  in  1  one-cycle pulse, dret executed
- `pwd_ref_i`  in  32*PWD_WORDS  reference password; word 0 in the LSBs
- `pwd_valid_i`  in  1  password beat valid
- `pwd_data_i`  in  32  password beat
- `pwd_ready_o`  out  1  beat accepted when `pwd_valid_i && pwd_ready_o`
- `challenge_o`  out  1  password challenge active
- `debug_mode_o`  out  1  debug granted; drives the regfile's debug_mode
- `unlock_fail_o`  out  1  one-cycle pulse per failed attempt
- `locked_o`  out  1  lockout active
- `fail_cnt_o`  out  $clog2(MAX_FAILS+1)  consecutive failure count

## Operation
- **Eligibility of `ebreak_i`:** M uses ebreakm, S uses ebreaks, U uses ebreaku. Priv 10 is never eligible.
- **Trigger:** `debug_req_i || (ebreak_i && eligible)`. If both are asserted in the same cycle, exactly one entry occurs.
- **States:** IDLE, CHALLENGE, CHECK, DEBUG, LOCKED.
- **IDLE:** on trigger, go to CHALLENGE. Beat index = 0, mismatch flag = 0, timeout counter = 0.
- **CHALLENGE:**
  - `challenge_o`=1 and `pwd_ready_o`=1.
  - Each accepted beat XOR-compares against word[index] and ORs the result into the mismatch flag. There is no early abort: every attempt takes all `PWD_WORDS` beats (constant time).
  - The timeout counter resets on each beat. Otherwise it increments.
  - After beat `PWD_WORDS-1`, go to CHECK.
  - If the counter reaches `TIMEOUT`, go to CHECK with the mismatch flag forced to 1.
  - Deasserting `debug_req_i` does not abort the challenge. Triggers are ignored in this state.
- **CHECK (1 cycle, `pwd_ready_o`=0):**
  - Match: go to DEBUG and clear `fail_cnt`.
  - Mismatch: pulse `unlock_fail_o` and increment `fail_cnt` (saturating at `MAX_FAILS`).
  - After a mismatch, if the new count equals `MAX_FAILS`, go to LOCKED and load the lock counter with `LOCK_CYCLES-1`. Otherwise go to IDLE.
- **DEBUG:** `debug_mode_o`=1 until `resume_i`, then go to IDLE. `resume_i` is ignored in every other state. Triggers are ignored in DEBUG.
- **LOCKED:**
  - `locked_o`=1. Triggers are ignored, and beats are not accepted (`pwd_ready_o`=0).
  - The lock counter decrements each cycle.
  - At 0, go to IDLE and clear `fail_cnt`.
- **Privilege:** `debug_mode_o` is never asserted outside DEBUG. `priv_lvl_i` has no effect on the grant beyond `ebreak_i` eligibility.

## Timing
- **Reset:** state IDLE and all counters 0. Every output is 0.
- **Reset mid-operation:** from any state, reset returns to IDLE in the next cycle and drops `debug_mode_o`/`locked_o`.
- Trigger in cycle t gives `challenge_o`=1 at t+1.
- Last beat accepted at t gives CHECK at t+1 and `debug_mode_o` (or `unlock_fail_o`) at t+2.
- `resume_i` at t gives `debug_mode_o`=0 at t+1. A new trigger is accepted from t+1.
- **Lockout:** entered at t, `locked_o` is high for exactly `LOCK_CYCLES` cycles; IDLE at t+`LOCK_CYCLES`.
- **Beat timeout:** with no beat after cycle t (or after entry), CHECK is reached `TIMEOUT` cycles later.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `DBG_UNLOCK_LOCKOUT_EN` defined: LOCKED state, lock counter and `locked_o` behave as above.
- Not defined:
  - LOCKED is removed and `locked_o` is tied 0.
  - Every failure returns to IDLE.
  - `fail_cnt` still counts and saturates at `MAX_FAILS`, but is cleared only by reset or a successful unlock.

## Test plan
- Reset with default params: all outputs 0. `debug_req_i`=1 → `challenge_o`=1 next cycle. Four correct beats → `debug_mode_o`=1 two cycles after the last beat. `resume_i` → 0 next cycle.
- `priv_lvl_i`=00, `dcsr_ebreaku_i`=0, `ebreak_i` pulse → stays IDLE, `challenge_o`=0. With ebreaku=1 → challenge starts. `priv_lvl_i`=10 with all enables=1 → no challenge.
- Wrong beat 1 of 4 → still 4 beats accepted, `unlock_fail_o` pulses once, `fail_cnt_o`=1, `debug_mode_o`=0.
- Three consecutive failures (`DBG_UNLOCK_LOCKOUT_EN` defined) → `locked_o` high for 1024 cycles. `debug_req_i` during lockout is ignored. Afterwards `fail_cnt_o`=0 and a correct password grants.
- No beats for 256 cycles in CHALLENGE → counted as a failure, returns to IDLE.
- Reset asserted in DEBUG and in CHALLENGE mid-beat → IDLE next cycle, `debug_mode_o`=0, `fail_cnt_o`=0.
